// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer
//   Downstream stage of the 12-bit triangle wave generator. Accepts one sample
//   per valid/ready handshake and shifts the 16-bit frame {CMD, sample} MSB
//   first to an SPI DAC in mode 0 (sclk idles low, data stable on rising edge).
//   After each frame cs_n is held high for a programmable hold time.
//   Optional feature macro: DAC_LDAC_EN adds an ldac_n strobe on the 2nd and
//   3rd hold cycles and lengthens the hold by three cycles.
`timescale 1ns/1ps
module dac_spi_serializer #(
    parameter int         CLK_DIV = 4,        // ref_clk cycles per sclk half-period (>= 1)
    parameter int         CS_HOLD = 2,        // minimum cs_n-high cycles between frames (>= 1)
    parameter logic [3:0] CMD     = 4'b0011   // command nibble sent ahead of the sample
) (
    input  logic        ref_clk,
    input  logic        rstn,
    input  logic [11:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        sclk,
    output logic        sdo,
    output logic        cs_n,
    output logic        busy,
    output logic        frame_done
`ifdef DAC_LDAC_EN
    ,
    output logic        ldac_n
`endif
);

`ifdef DAC_LDAC_EN
    localparam int HOLD_LEN = CS_HOLD + 3;
`else
    localparam int HOLD_LEN = CS_HOLD;
`endif

    localparam int DIV_W  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
    localparam int HOLD_W = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LEN - 1);
    localparam logic [3:0]        BIT_LAST  = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    // The bit currently on the wire lives in sdo_q; shift_q holds the 15 bits
    // still to come, next bit in [14].
    logic [14:0]       shift_q, shift_d;
    logic [DIV_W-1:0]  div_q, div_d;       // position inside the current sclk half-period
    logic [3:0]        bit_q, bit_d;       // index of the bit on the wire, 0 = MSB
    logic [HOLD_W-1:0] hold_q, hold_d;     // position inside the hold window

    logic s_ready_q, s_ready_d;
    logic cs_n_q, cs_n_d;
    logic sclk_q, sclk_d;
    logic sdo_q, sdo_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;
`ifdef DAC_LDAC_EN
    logic ldac_n_q, ldac_n_d;
`endif

    // Next-state and next-output logic; every pin comes straight from a flop.
    always_comb begin
        // NOTE: every *_d gets a default first, so no path through the case can infer a latch.
        state_d      = state_q;
        shift_d      = shift_q;
        div_d        = div_q;
        bit_d        = bit_q;
        hold_d       = hold_q;
        s_ready_d    = s_ready_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        sdo_d        = sdo_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
`ifdef DAC_LDAC_EN
        ldac_n_d     = 1'b1;
`endif

        case (state_q)
            IDLE: begin
                // Ready rises on the first cycle after reset and stays up until an accept.
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    state_d   = SHIFT;
                    shift_d   = {CMD[2:0], s_data};
                    sdo_d     = CMD[3];
                    div_d     = '0;
                    bit_d     = '0;
                    s_ready_d = 1'b0;
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // End of the low phase: rising edge, sdo untouched.
                        sclk_d = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        // End of the last high phase: release the DAC.
                        state_d      = HOLD;
                        hold_d       = '0;
                        cs_n_d       = 1'b1;
                        sclk_d       = 1'b0;
                        sdo_d        = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        // End of a bit: falling edge and the next bit goes out together.
                        bit_d   = bit_q + 4'd1;
                        sclk_d  = 1'b0;
                        sdo_d   = shift_q[14];
                        shift_d = {shift_q[13:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    s_ready_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
`ifdef DAC_LDAC_EN
                    // Next cycle is hold cycle 2 or 3: strobe LDAC, strictly after cs_n rose.
                    if ((hold_q == HOLD_W'(0)) || (hold_q == HOLD_W'(1))) begin
                        ldac_n_d = 1'b0;
                    end
`endif
                end
            end

            default: begin
                state_d   = IDLE;
                s_ready_d = 1'b0;
                busy_d    = 1'b0;
                cs_n_d    = 1'b1;
                sclk_d    = 1'b0;
                sdo_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset is synchronous and active-low and aborts any frame.
    always_ff @(posedge ref_clk) begin
        // NOTE: non-blocking assignments, so every flop samples the pre-edge value of every other.
        if (!rstn) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            div_q        <= '0;
            bit_q        <= '0;
            hold_q       <= '0;
            s_ready_q    <= 1'b0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            sdo_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef DAC_LDAC_EN
            ldac_n_q     <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            hold_q       <= hold_d;
            s_ready_q    <= s_ready_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            sdo_q        <= sdo_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef DAC_LDAC_EN
            ldac_n_q     <= ldac_n_d;
`endif
        end
    end

    assign s_ready    = s_ready_q;
    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign sdo        = sdo_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
`ifdef DAC_LDAC_EN
    assign ldac_n     = ldac_n_q;
`endif

endmodule
